ycr_aes_arb: RTL and testbench



---
 rtl/ycr_aes_arb.sv | 209 ++++++++++++++++++++
 tb/tb_ycr_aes_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_aes_arb.sv
`default_nettype none
// ============================================================================
// Module   : ycr_aes_arb
// Purpose  : Two-core arbiter and wake sequencer for the shared AES engine.
//            It grants the engine to one core at a time, with round-robin
//            fairness between the two cores. It raises the AES clock-gate
//            request before the first grant. It drops that request only after
//            the engine reports idle and no core is still requesting.
// Ports    : core_clk_int  in   core clock (ungated)
//            rst_n         in   asynchronous active-low reset
//            core_req[1:0] in   per-core level request
//            core_done[1:0]in   per-core one-cycle release pulse
//            core_gnt[1:0] out  one-hot grant (registered)
//            aes_sel       out  owner index for the AES datapath mux (held)
//            aes_req       out  AES clock-gate source request (registered)
//            aes_idle      in   engine idle, synchronous to core_clk_int
//            busy          out  arbiter not in IDLE (registered)
//            arb_timeout   out  one-cycle pulse on forced grant revocation
// Config   : define YCR_AES_ARB_TIMEOUT_EN to enable the grant-hold timeout
//            (TIMEOUT_CYC cycles). When it is undefined, arb_timeout is tied
//            low and a grant is held for as long as the owner keeps it.
// Revision : 1.0 - initial release
// ============================================================================
module ycr_aes_arb #(
    parameter int WAKE_CYC    = 2,     // clock-gate enable latency, 0..15
    parameter int TIMEOUT_CYC = 1024   // grant hold limit, 1..65535
) (
    input  logic       core_clk_int,
    input  logic       rst_n,
    input  logic [1:0] core_req,
    input  logic [1:0] core_done,
    output logic [1:0] core_gnt,
    output logic       aes_sel,
    output logic       aes_req,
    input  logic       aes_idle,
    output logic       busy,
    output logic       arb_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAKE  = 2'd1,
        ST_GRANT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // WAKE occupies exactly WAKE_CYC register cycles. The counter is loaded
    // with WAKE_CYC-1 and the state leaves WAKE on the cycle where it reads 0.
    localparam logic [3:0] c_WAKE_LOAD = (WAKE_CYC > 0) ? 4'(WAKE_CYC - 1) : 4'd0;
    localparam logic       c_WAKE_SKIP = (WAKE_CYC == 0);

    // Out-of-range parameters leave this marker scope in the elaborated
    // hierarchy. That makes a bad configuration easy to spot in netlists.
    if (WAKE_CYC < 0 || WAKE_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_param_range_error
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic        r_rr;          // index of the core that wins a tie
    logic        w_rr_nxt;
    logic [3:0]  r_wake_cnt;
    logic [3:0]  w_wake_nxt;
    logic        w_timeout_hit;
    logic        w_timeout_nxt;
    logic        w_req_own;
    logic        w_req_oth;

    logic [1:0]  r_gnt;
    logic        r_aes_sel;
    logic        r_aes_req;
    logic        r_busy;
    logic        r_timeout;

    assign w_req_own = core_req[r_owner];
    assign w_req_oth = core_req[~r_owner];

`ifdef YCR_AES_ARB_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_hold;

    // Zero outside GRANT, so the count starts at 0 on every GRANT entry.
    // It reaches TIMEOUT_CYC-1 on the last cycle the grant may be held.
    always_ff @(posedge core_clk_int or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 16'd0;
        end else if (r_state != ST_GRANT) begin
            r_hold <= 16'd0;
        end else begin
            r_hold <= r_hold + 16'd1;
        end
    end

    assign w_timeout_hit = (r_state == ST_GRANT) && (r_hold == c_TIMEOUT_LAST);
`else
    assign w_timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rr_nxt      = r_rr;
        w_wake_nxt    = r_wake_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|core_req) begin
                    w_owner_nxt = core_req[r_rr] ? r_rr : ~r_rr;
                    w_wake_nxt  = c_WAKE_LOAD;
                    w_state_nxt = c_WAKE_SKIP ? ST_GRANT : ST_WAKE;
                end
            end
            ST_WAKE: begin
                // An abandoned request still has to pass through DRAIN. The
                // clock is already being woken and must settle before IDLE.
                if (!w_req_own) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_wake_cnt == 4'd0) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_wake_nxt = r_wake_cnt - 4'd1;
                end
            end
            ST_GRANT: begin
                // A normal release takes precedence, so the timeout pulse
                // marks only grants that really had to be taken back.
                if (core_done[r_owner] || !w_req_own) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_timeout_hit) begin
                    w_state_nxt   = ST_DRAIN;
                    w_timeout_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (aes_idle) begin
                    if (w_req_oth) begin
                        w_owner_nxt = ~r_owner;
                        w_state_nxt = ST_GRANT;
                    end else if (w_req_own) begin
                        w_state_nxt = ST_GRANT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // On each GRANT entry, give priority to the core that was not just
        // granted.
        if ((w_state_nxt == ST_GRANT) && (r_state != ST_GRANT)) begin
            w_rr_nxt = ~w_owner_nxt;
        end
        if (w_timeout_nxt) begin
            w_rr_nxt = ~r_owner;
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk_int or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_rr       <= 1'b0;
            r_wake_cnt <= 4'd0;
            r_gnt      <= 2'b00;
            r_aes_sel  <= 1'b0;
            r_aes_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr       <= w_rr_nxt;
            r_wake_cnt <= w_wake_nxt;
            r_timeout  <= w_timeout_nxt;
            // Outputs are decoded from the next state. Every change then
            // appears one cycle after the sampled event, and no grant can
            // ever be registered without aes_req.
            r_aes_req  <= (w_state_nxt != ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_GRANT) begin
                r_gnt     <= w_owner_nxt ? 2'b10 : 2'b01;
                r_aes_sel <= w_owner_nxt;
            end else begin
                r_gnt     <= 2'b00;
            end
        end
    end

    assign core_gnt    = r_gnt;
    assign aes_sel     = r_aes_sel;
    assign aes_req     = r_aes_req;
    assign busy        = r_busy;
    assign arb_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ycr_aes_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycr_aes_arb
// Purpose  : Directed, self-checking bench for ycr_aes_arb (WAKE_CYC=2,
//            TIMEOUT_CYC=8). Before each clock edge the bench pushes the
//            expected outputs for that edge to a queue. It pops and compares
//            them 1 ns after the edge. A negedge monitor checks that grants
//            are one-hot and that no grant is ever active without aes_req.
//            The timeout scenario follows YCR_AES_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ycr_aes_arb;

    logic       clk;
    logic       rst_n;
    logic [1:0] core_req;
    logic [1:0] core_done;
    logic [1:0] core_gnt;
    logic       aes_sel;
    logic       aes_req;
    logic       aes_idle;
    logic       busy;
    logic       arb_timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] gnt;
        logic       sel;
        logic       areq;
        logic       bsy;
        logic       to;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];

    ycr_aes_arb #(
        .WAKE_CYC    (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .core_clk_int (clk),
        .rst_n        (rst_n),
        .core_req     (core_req),
        .core_done    (core_done),
        .core_gnt     (core_gnt),
        .aes_sel      (aes_sel),
        .aes_req      (aes_req),
        .aes_idle     (aes_idle),
        .busy         (busy),
        .arb_timeout  (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariant monitor: grants are one-hot, and no grant without aes_req.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ((core_gnt !== 2'b11) && ((core_gnt === 2'b00) || (aes_req === 1'b1)))
            else begin
                failures++;
                $error("FAIL invariant gnt=%b aes_req=%b required one-hot grant with aes_req=1",
                       core_gnt, aes_req);
            end
        end
    end

    task automatic push_exp(input string tag, input logic [1:0] g, input logic s,
                            input logic r, input logic t);
        exp_t e;
        e.gnt  = g;
        e.sel  = s;
        e.areq = r;
        e.bsy  = r;
        e.to   = t;
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic compare_out();
        exp_t  e;
        string tag;
        e   = sbq.pop_front();
        tag = tagq.pop_front();
        checks++;
        assert (core_gnt === e.gnt) else begin
            failures++;
            $error("FAIL %s core_gnt observed=%b expected=%b", tag, core_gnt, e.gnt);
        end
        checks++;
        assert (aes_sel === e.sel) else begin
            failures++;
            $error("FAIL %s aes_sel observed=%b expected=%b", tag, aes_sel, e.sel);
        end
        checks++;
        assert (aes_req === e.areq) else begin
            failures++;
            $error("FAIL %s aes_req observed=%b expected=%b", tag, aes_req, e.areq);
        end
        checks++;
        assert (busy === e.bsy) else begin
            failures++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, e.bsy);
        end
        checks++;
        assert (arb_timeout === e.to) else begin
            failures++;
            $error("FAIL %s arb_timeout observed=%b expected=%b", tag, arb_timeout, e.to);
        end
    endtask

    // Drive inputs for one edge, queue the outputs expected after it, then
    // sample 1 ns past the edge.
    task automatic cyc(input logic [1:0] req, input logic [1:0] done, input logic idle,
                       input logic [1:0] e_gnt, input logic e_sel, input logic e_req,
                       input logic e_to, input string tag);
        core_req  = req;
        core_done = done;
        aes_idle  = idle;
        push_exp(tag, e_gnt, e_sel, e_req, e_to);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Assert reset between edges. Outputs must clear without waiting for a
    // clock edge.
    task automatic do_reset(input string tag);
        core_req  = 2'b00;
        core_done = 2'b00;
        rst_n     = 1'b0;
        #2;
        push_exp(tag, 2'b00, 1'b0, 1'b0, 1'b0);
        compare_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        core_req  = 2'b00;
        core_done = 2'b00;
        aes_idle  = 1'b1;
        #3;
        push_exp("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        compare_out();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from core0: wake for 2 cycles, then grant, then release.
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t1_req");
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t1_wake");
        cyc(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t1_gnt");
        cyc(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t1_hold");
        cyc(2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t1_done");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "t1_idle");

        // Simultaneous requests after reset: core0 first, then core1 after one gap.
        do_reset("t2_reset");
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t2_wake0");
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t2_wake1");
        cyc(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t2_gnt0");
        cyc(2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t2_gap");
        cyc(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "t2_gnt1");
        cyc(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "t2_hold1");
        cyc(2'b00, 2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, "t2_done1");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, "t2_idle");

        // Handover delayed by a busy engine: no grant until aes_idle rises.
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, "t3_wake0");
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, "t3_wake1");
        cyc(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t3_gnt0");
        cyc(2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "t3_done0");
        for (int i = 0; i < 5; i++) begin
            cyc(2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "t3_drain_busy");
        end
        cyc(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "t3_gnt1");
        cyc(2'b00, 2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, "t3_done1");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, "t3_idle");
        do_reset("t3_reset_sel");

        // Request abandoned during WAKE: no grant, DRAIN, then IDLE.
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t4_wake");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t4_abandon");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "t4_idle");
        // core_done from the non-owner is ignored.
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t4_wake0");
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t4_wake1");
        cyc(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t4_gnt0");
        cyc(2'b01, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t4_foreign_done");
        cyc(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t4_hold");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t4_req_fall");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "t4_idle2");

        // Reset during GRANT clears everything, and rr returns to core0 priority.
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t5_wake0");
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t5_wake1");
        cyc(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t5_gnt0");
        do_reset("t5_reset_in_grant");
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t5_wake0b");
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t5_wake1b");
        cyc(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t5_gnt_core0");
        cyc(2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t5_done0");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "t5_idle");

        // Core0 holds the grant while core1 is pending.
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t6_wake0");
        cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t6_wake1");
        cyc(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t6_gnt0");
        for (int i = 0; i < 7; i++) begin
            cyc(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t6_hold");
        end
`ifdef YCR_AES_ARB_TIMEOUT_EN
        cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, "t6_timeout");
        cyc(2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "t6_gnt1");
        cyc(2'b00, 2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, "t6_done1");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, "t6_idle");
`else
        for (int i = 0; i < 12; i++) begin
            cyc(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "t6_hold_no_timeout");
        end
        cyc(2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "t6_done0");
        cyc(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "t6_gnt1");
        cyc(2'b00, 2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, "t6_done1");
        cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, "t6_idle");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
